// File: rtl/snake_engine.sv
// snake_engine: grid snake with circular body buffer, growth, wall/self collision and pixel hit queries
// Ports: uclk/rst (async active-low) clock and reset; step move tick; accion direction request
//   (0 none, 1 up, 2 down, 3 left, 4 right); fruit_x/fruit_y fruit cell; PixelX/PixelY pixel query;
//   head_x/head_y head cell; length segment count; comer eat pulse; game_over collision pulse;
//   state FSM code (0 idle, 1 run, 2 dead); pix_head/pix_body registered pixel hit results.
module snake_engine #(
  parameter int GRID_W     = 100,
  parameter int GRID_H     = 75,
  parameter int CELL_LOG2  = 3,
  parameter int MAX_LEN    = 32,
  parameter int INIT_X     = 4,
  parameter int INIT_Y     = 4,
  parameter int WRAP       = 0,
  parameter int DEAD_TICKS = 4,
  parameter int XW         = $clog2(GRID_W),
  parameter int YW         = $clog2(GRID_H),
  parameter int LW         = $clog2(MAX_LEN + 1)
) (
  input  logic          uclk,
  input  logic          rst,
  input  logic          step,
  input  logic [2:0]    accion,
  input  logic [XW-1:0] fruit_x,
  input  logic [YW-1:0] fruit_y,
  input  logic [10:0]   PixelX,
  input  logic [10:0]   PixelY,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          comer,
  output logic          game_over,
  output logic [1:0]    state,
  output logic          pix_head,
  output logic          pix_body
);
  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DW = $clog2(DEAD_TICKS + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;
  state_t st, st_n;
  logic [2:0] dir, dir_n, d;
  logic [XW-1:0] hx, hx_n, nx;
  logic [YW-1:0] hy, hy_n, ny;
  logic [XW-1:0] bx [MAX_LEN];
  logic [YW-1:0] by [MAX_LEN];
  logic [LW-1:0] len, len_n;
  logic [PW-1:0] ptr, ptr_n, i;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [10:0] cx, cy;
  logic valid, rev, wall, eat, self_hit, body, wr, comer_n, go_n, in_grid, hmatch;

  assign cx = PixelX >> CELL_LOG2;
  assign cy = PixelY >> CELL_LOG2;
  assign in_grid = cx < 11'(GRID_W) && cy < 11'(GRID_H);
  assign hmatch = cx == 11'(hx) && cy == 11'(hy);

  // A request takes effect on the same step it arrives with; reversal is only blocked once there is a body.
  always_comb begin
    valid = accion >= 3'd1 && accion <= 3'd4;
    rev = (dir == 3'd1 && accion == 3'd2) || (dir == 3'd2 && accion == 3'd1) ||
          (dir == 3'd3 && accion == 3'd4) || (dir == 3'd4 && accion == 3'd3);
    d = (valid && st != DEAD && !(len > LW'(1) && rev)) ? accion : dir;
    wall = (d == 3'd3 && hx == '0) || (d == 3'd4 && hx == XW'(GRID_W - 1)) ||
           (d == 3'd1 && hy == '0) || (d == 3'd2 && hy == YW'(GRID_H - 1));
    nx = d == 3'd3 ? (hx == '0 ? XW'(GRID_W - 1) : hx - 1'b1) :
         d == 3'd4 ? (hx == XW'(GRID_W - 1) ? '0 : hx + 1'b1) : hx;
    ny = d == 3'd1 ? (hy == '0 ? YW'(GRID_H - 1) : hy - 1'b1) :
         d == 3'd2 ? (hy == YW'(GRID_H - 1) ? '0 : hy + 1'b1) : hy;
    eat = nx == fruit_x && ny == fruit_y;
  end

  // Segment k sits at (ptr-k) mod MAX_LEN; the tail only blocks the move when eating keeps it in place.
  always_comb begin
    self_hit = 1'b0;
    body = 1'b0;
    i = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      i = PW'((int'(ptr) + MAX_LEN - k) % MAX_LEN);
      if (k < int'(len)) begin
        if ((k < int'(len) - 1 || eat) && bx[i] == nx && by[i] == ny) self_hit = 1'b1;
        if (k > 0 && 11'(bx[i]) == cx && 11'(by[i]) == cy) body = 1'b1;
      end
    end
  end

  always_comb begin
    st_n = st;
    dir_n = d;
    hx_n = hx;
    hy_n = hy;
    len_n = len;
    ptr_n = ptr;
    dcnt_n = dcnt;
    comer_n = 1'b0;
    go_n = 1'b0;
    wr = 1'b0;
    if (st == IDLE && valid) st_n = RUN;
    if (st == RUN && step) begin
      if ((wall && WRAP == 0) || self_hit) begin
        go_n = 1'b1;
        st_n = DEAD;
      end else begin
        wr = 1'b1;
        ptr_n = (ptr == PW'(MAX_LEN - 1)) ? '0 : ptr + 1'b1;
        hx_n = nx;
        hy_n = ny;
        comer_n = eat;
        if (eat && len < LW'(MAX_LEN)) len_n = len + 1'b1;
      end
    end
    if (st == DEAD && step) begin
      if (dcnt == DW'(DEAD_TICKS - 1)) begin
        st_n = IDLE;
        dcnt_n = '0;
        hx_n = XW'(INIT_X);
        hy_n = YW'(INIT_Y);
        len_n = LW'(1);
        dir_n = 3'd4;
        ptr_n = '0;
      end else begin
        dcnt_n = dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge uclk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      dir <= 3'd4;
      hx <= XW'(INIT_X);
      hy <= YW'(INIT_Y);
      len <= LW'(1);
      ptr <= '0;
      dcnt <= '0;
      comer <= 1'b0;
      game_over <= 1'b0;
      pix_head <= 1'b0;
      pix_body <= 1'b0;
    end else begin
      st <= st_n;
      dir <= dir_n;
      hx <= hx_n;
      hy <= hy_n;
      len <= len_n;
      ptr <= ptr_n;
      dcnt <= dcnt_n;
      comer <= comer_n;
      game_over <= go_n;
      pix_head <= in_grid && hmatch;
      pix_body <= in_grid && !hmatch && body;
    end
  end

  // The slot at ptr is refreshed with the head whenever no move happens, so the buffer needs no reset
  // and always holds the head at ptr before the first move after reset or re-init.
  always_ff @(posedge uclk) begin
    if (wr) begin
      bx[ptr_n] <= nx;
      by[ptr_n] <= ny;
    end else begin
      bx[ptr] <= hx;
      by[ptr] <= hy;
    end
  end

  assign head_x = hx;
  assign head_y = hy;
  assign length = len;
  assign state = st;
endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised successor to the single-head snake logic. Keeps a snake of up to MAX_LEN segments on a cell grid in a circular body buffer.
- Moves the snake one cell per step tick, grows it on fruit, and detects wall and self collision. Optionally wraps at the walls instead of dying.
- Answers per-pixel head/body hit queries for the VGA colour mux. Sits between the input decoder (accion, step tick) and the fruit/graphics blocks.

Parameters:
- GRID_W, 100, grid width in cells.
- GRID_H, 75, grid height in cells.
- CELL_LOG2, 3, log2 of cell size in pixels (default gives 800x600).
- MAX_LEN, 32, body buffer depth (maximum snake length).
- INIT_X, 4, head X cell after reset or re-init.
- INIT_Y, 4, head Y cell after reset or re-init.
- WRAP, 0, 0 = walls kill, 1 = walls wrap.
- DEAD_TICKS, 4, step ticks spent in DEAD before re-init.
- XW/YW/LW, derived: clog2(GRID_W), clog2(GRID_H), clog2(MAX_LEN+1).

Ports:
- uclk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- step, in, 1, one-cycle move tick.
- accion, in, 3, direction request: 0 none, 1 up, 2 down, 3 left, 4 right; 5-7 ignored.
- fruit_x, in, XW, fruit cell X.
- fruit_y, in, YW, fruit cell Y.
- PixelX, in, 11, pixel query X.
- PixelY, in, 11, pixel query Y.
- head_x, out, XW, head cell X.
- head_y, out, YW, head cell Y.
- length, out, LW, current segment count (1..MAX_LEN).
- comer, out, 1, one-cycle pulse: fruit eaten.
- game_over, out, 1, one-cycle pulse: collision.
- state, out, 2, FSM state code.
- pix_head, out, 1, registered: query pixel lies in the head cell.
- pix_body, out, 1, registered: query pixel lies in a non-head segment.

Behaviour:
- Reset (rst=0, async):
  - head=(INIT_X,INIT_Y), length=1, dir=4 (right), buffer head pointer=0.
  - comer=0, game_over=0, pix_*=0, state=IDLE, dead counter=0.
- State codes: IDLE=0, RUN=1, DEAD=2.
- IDLE:
  - Any valid accion (1-4) latches dir and moves to RUN on the next cycle.
  - step is ignored.
- Direction:
  - Valid accion is latched every cycle in IDLE/RUN.
  - When length>1, a request that reverses dir is ignored.
  - If accion and step coincide, the new dir applies to that step.
- RUN, on step at cycle N, with outputs updated at N+1:
  - next = head + dir.
  - Wall case, WRAP=0: x=0 moving left, x=GRID_W-1 moving right, y=0 moving up, or y=GRID_H-1 moving down -> collision.
  - Wall case, WRAP=1: coordinate wraps to the opposite edge (0 <-> GRID_W-1, 0 <-> GRID_H-1).
  - Self collision: next equals any segment k in 0..length-1. The tail (k=length-1) is excluded unless eating, because it vacates on this step.
  - On collision: game_over=1 for one cycle; head, length and buffer are frozen; state=DEAD.
  - Otherwise: buffer pointer increments mod MAX_LEN and next is written there as the new head.
  - Eat: if next==(fruit_x,fruit_y), comer=1 for one cycle and length increments. At MAX_LEN, length saturates and the tail advances (comer still pulses).
- Buffer addressing: segment k lives at (ptr-k) mod MAX_LEN for k<length. Entries at k>=length are don't-care and never hit.
- DEAD:
  - Counts step ticks.
  - On the DEAD_TICKS-th step, re-initialises to reset values (except rst-only logic) and moves to IDLE.
  - accion is ignored.
- Pixel query:
  - cell = (PixelX>>CELL_LOG2, PixelY>>CELL_LOG2). Result is registered with 1-cycle latency.
  - Cell outside the grid -> both outputs 0.
  - Head match sets pix_head and suppresses pix_body.
  - Valid in all states; the frozen snake remains visible in DEAD.
- Simultaneous events:
  - step in the same cycle as rst: rst wins.
  - comer and game_over are never both 1; collision has priority over eat.

Test Plan:
- Reset, accion=4 for one cycle, then 3 steps -> state 0->1, head (4,4)->(7,4), length=1, no pulses.
- fruit=(5,4), head (4,4) moving right, step -> comer=1 for exactly one cycle, length=2, head=(5,4); next step -> segment at (5,4) becomes body, tail not left behind.
- WRAP=0, head (0,10), dir=3, step -> game_over pulse, state=2; 4 steps later -> state=0, head=(4,4), length=1. WRAP=1 same stimulus -> head=(99,10), no game_over.
- Length-5 snake turning back on itself (right, down, left, up) -> game_over on the up step. Same loop with length 4 (tail vacates) -> no collision.
- Length 2, dir=4, accion=3 -> ignored, head x increments; accion=1 -> head y decrements.
- Grow to MAX_LEN=32, eat again -> length stays 32, comer pulses. Pixel (8*k+3, 35) for a body cell -> pix_body=1 one cycle later; head cell pixel -> pix_head=1, pix_body=0; PixelX=805 -> both 0.
